// File: rtl/stack_alu_pkg.sv
// Shared opcode encodings and controller states for the stack-machine ALU.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_SWAP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MUL_BUSY = 2'd2
  } state_t;

endpackage

// File: rtl/stack_alu_mul_seq.sv
// N-cycle shift-add multiplier: start latches operands, done marks the final
// step, and product carries that step's result in the same cycle.
module stack_alu_mul_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic           busy;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] step_sum;

  assign step_sum = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CW'(N - 1));
  assign product  = step_sum;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{N{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (busy) begin
      acc    <= step_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/param_stack_alu.sv
// Stack-machine ALU: LIFO operand stack, valid/ready command port, single-cycle
// ops plus a sequential multiply, with full/empty/underflow reporting.
module param_stack_alu
  import stack_alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic         out_valid,
  output logic         overflow,
  output logic         error,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  state_t         state, state_next;
  logic [SW-1:0]  sp;
  logic [N-1:0]   mem [DEPTH];

  logic [AW-1:0]  push_addr, top_addr, nos_addr;
  logic [N-1:0]   top, nos;
  logic           has1, has2, accept, reject;
  logic [N:0]     sum, diff;

  logic           swap_pending;
  logic [N-1:0]   swap_data;

  logic           mul_start, mul_done;
  logic [2*N-1:0] mul_product;

  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [N-1:0]   wr_data;

  // With sp==DEPTH the low AW bits wrap to 0, so top/nos still land on the
  // highest two entries.
  assign push_addr = sp[AW-1:0];
  assign top_addr  = push_addr - 1'b1;
  assign nos_addr  = push_addr - 2'd2;
  assign top       = mem[top_addr];
  assign nos       = mem[nos_addr];

  assign empty    = (sp == '0);
  assign full     = (sp == SW'(DEPTH));
  assign has1     = (sp >= SW'(1));
  assign has2     = (sp >= SW'(2));
  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid && op_ready;

  assign sum  = {1'b0, nos} + {1'b0, top};
  assign diff = {1'b0, nos} - {1'b0, top};

  always_comb begin
    reject = 1'b0;
    unique case (opcode)
      OP_PUSH:                        reject = full;
      OP_POP:                         reject = !has1;
      OP_DUP:                         reject = !has1 || full;
      OP_ADD, OP_SUB, OP_MUL, OP_SWAP: reject = !has2;
      default:                        reject = 1'b0;
    endcase
  end

  assign mul_start = accept && (opcode == OP_MUL) && !reject;

  stack_alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (nos),
    .b       (top),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (accept) state_next = mul_start ? ST_MUL_BUSY : ST_EXEC;
      ST_EXEC:     state_next = ST_IDLE;
      ST_MUL_BUSY: if (mul_done) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // SWAP needs two writes through the single port; the second lands in EXEC.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state == ST_EXEC && swap_pending) begin
      wr_en   = 1'b1;
      wr_addr = nos_addr;
      wr_data = swap_data;
    end else if (mul_done) begin
      wr_en   = 1'b1;
      wr_addr = nos_addr;
      wr_data = mul_product[N-1:0];
    end else if (accept && !reject) begin
      unique case (opcode)
        OP_PUSH: begin wr_en = 1'b1; wr_addr = push_addr; wr_data = in;          end
        OP_ADD:  begin wr_en = 1'b1; wr_addr = nos_addr;  wr_data = sum[N-1:0];  end
        OP_SUB:  begin wr_en = 1'b1; wr_addr = nos_addr;  wr_data = diff[N-1:0]; end
        OP_DUP:  begin wr_en = 1'b1; wr_addr = push_addr; wr_data = top;         end
        OP_SWAP: begin wr_en = 1'b1; wr_addr = top_addr;  wr_data = nos;         end
        default: wr_en = 1'b0;
      endcase
    end
  end

  // NOTE: the stack array is deliberately left out of reset so it maps onto
  // plain storage; SP alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      sp           <= '0;
      out          <= '0;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
      error        <= 1'b0;
      swap_pending <= 1'b0;
      swap_data    <= '0;
    end else begin
      state     <= state_next;
      out_valid <= 1'b0;
      error     <= 1'b0;
      if (state == ST_EXEC) swap_pending <= 1'b0;

      if (accept) begin
        if (reject) begin
          error <= 1'b1;
        end else begin
          unique case (opcode)
            OP_PUSH: sp <= sp + 1'b1;
            OP_POP: begin
              out       <= top;
              sp        <= sp - 1'b1;
              out_valid <= 1'b1;
            end
            OP_ADD: begin
              out       <= sum[N-1:0];
              overflow  <= sum[N];
              sp        <= sp - 1'b1;
              out_valid <= 1'b1;
            end
            OP_SUB: begin
              out       <= diff[N-1:0];
              overflow  <= diff[N];
              sp        <= sp - 1'b1;
              out_valid <= 1'b1;
            end
            OP_DUP: begin
              out       <= top;
              sp        <= sp + 1'b1;
              out_valid <= 1'b1;
            end
            OP_SWAP: begin
              swap_pending <= 1'b1;
              swap_data    <= top;
            end
            default: ;
          endcase
        end
      end

      if (mul_done) begin
        out       <= mul_product[N-1:0];
        overflow  <= |mul_product[2*N-1:N];
        sp        <= sp - 1'b1;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_stack_alu.sv
// Self-checking bench for param_stack_alu (N=4, DEPTH=4) against a queue-based
// stack model, with directed scenarios followed by random command streams.
module tb_param_stack_alu;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << N) - 1;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, ADD = 3'd3,
                         MUL = 3'd4, SUB = 3'd5, DUP = 3'd6, SWAP = 3'd7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [2:0]   opcode = 3'd0;
  logic [N-1:0] in = '0;
  logic [N-1:0] out;
  logic         out_valid, overflow, error, empty, full;

  int n_checks = 0;
  int n_errors = 0;

  int stk[$];
  int m_out = 0;
  int m_ov  = 0;

  param_stack_alu #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .overflow  (overflow),
    .error     (error),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b1;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    m_out = 0;
    m_ov  = 0;
  endtask

  // Issues one command, updates the model, and checks the DUT response.
  task automatic do_op(input logic [2:0] op, input int val);
    int  sz, a, b, r, waited, cycles;
    bit  exp_err, exp_vld, is_mul;
    exp_err = 0; exp_vld = 0; is_mul = 0;
    @(negedge clk);
    waited = 0;
    while (!op_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!op_ready) begin
      n_errors++;
      $display("FAIL ready_timeout op=%0d op_ready=%b required 1", op, op_ready);
      return;
    end
    n_checks++;
    if (out_valid !== 1'b0 || error !== 1'b0) begin
      n_errors++;
      $display("FAIL pulse_width out_valid=%b error=%b required 0 0", out_valid, error);
    end

    sz = stk.size();
    unique case (op)
      PUSH: if (sz == DEPTH) exp_err = 1; else stk.push_back(val & MASK);
      POP:  if (sz < 1) exp_err = 1;
            else begin m_out = stk.pop_back(); exp_vld = 1; end
      ADD, SUB, MUL: if (sz < 2) exp_err = 1;
            else begin
              b = stk.pop_back();
              a = stk.pop_back();
              if (op == ADD)      begin r = a + b; m_ov = (r > MASK); end
              else if (op == SUB) begin r = a - b; m_ov = (a < b);    end
              else                begin r = a * b; m_ov = (r > MASK); is_mul = 1; end
              m_out = r & MASK;
              stk.push_back(m_out);
              exp_vld = 1;
            end
      DUP:  if (sz < 1 || sz == DEPTH) exp_err = 1;
            else begin m_out = stk[$]; stk.push_back(m_out); exp_vld = 1; end
      SWAP: if (sz < 2) exp_err = 1;
            else begin
              a = stk[sz-1];
              stk[sz-1] = stk[sz-2];
              stk[sz-2] = a;
            end
      default: ;
    endcase

    opcode   = op;
    in       = N'(val);
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    opcode   = 3'($urandom_range(0, 7));
    in       = N'($urandom_range(0, MASK));

    n_checks++;
    if (op_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_after_accept op=%0d op_ready=%b required 0", op, op_ready);
    end
    n_checks++;
    if (error !== exp_err) begin
      n_errors++;
      $display("FAIL error_flag op=%0d error=%b required %b", op, error, exp_err);
    end

    if (is_mul) begin
      cycles = 1;
      while (!out_valid && cycles < 20) begin
        n_checks++;
        if (op_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL mul_ready cycle=%0d op_ready=%b required 0", cycles, op_ready);
        end
        @(negedge clk);
        cycles++;
      end
      n_checks++;
      if (cycles != N + 1) begin
        n_errors++;
        $display("FAIL mul_latency cycles=%0d required %0d", cycles, N + 1);
      end
    end

    n_checks++;
    if (out_valid !== exp_vld || out !== N'(m_out) || overflow !== m_ov[0]) begin
      n_errors++;
      $display("FAIL result op=%0d out_valid=%b out=%0d ov=%b required %b %0d %b",
               op, out_valid, out, overflow, exp_vld, m_out, m_ov[0]);
    end
    n_checks++;
    if (empty !== (stk.size() == 0) || full !== (stk.size() == DEPTH)) begin
      n_errors++;
      $display("FAIL sp_flags op=%0d empty=%b full=%b required %b %b",
               op, empty, full, stk.size() == 0, stk.size() == DEPTH);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (out !== '0 || out_valid !== 1'b0 || overflow !== 1'b0 || error !== 1'b0 ||
        empty !== 1'b1 || full !== 1'b0 || op_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state out=%0d ov=%b ovf=%b err=%b empty=%b full=%b rdy=%b required 0 0 0 0 1 0 1",
               out, out_valid, overflow, error, empty, full, op_ready);
    end
  endtask

  task automatic test_add_pop();
    apply_reset();
    do_op(PUSH, 3);
    do_op(PUSH, 5);
    do_op(ADD, 0);
    n_checks++;
    if (out !== 4'd8 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL add_3_5 out=%0d ov=%b required 8 0", out, overflow);
    end
    do_op(POP, 0);
    n_checks++;
    if (out !== 4'd8 || empty !== 1'b1) begin
      n_errors++;
      $display("FAIL pop_after_add out=%0d empty=%b required 8 1", out, empty);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    do_op(PUSH, 9);
    do_op(PUSH, 9);
    do_op(ADD, 0);
    n_checks++;
    if (out !== 4'd2 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL add_carry out=%0d ov=%b required 2 1", out, overflow);
    end
    do_op(PUSH, 2);
    do_op(PUSH, 5);
    do_op(SUB, 0);
    n_checks++;
    if (out !== 4'd13 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL sub_borrow out=%0d ov=%b required 13 1", out, overflow);
    end
  endtask

  task automatic test_mul();
    apply_reset();
    do_op(PUSH, 7);
    do_op(PUSH, 3);
    do_op(MUL, 0);
    n_checks++;
    if (out !== 4'd5 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL mul_7_3 out=%0d ov=%b required 5 1", out, overflow);
    end
    do_op(PUSH, 3);
    do_op(PUSH, 4);
    do_op(MUL, 0);
    n_checks++;
    if (out !== 4'd12 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_3_4 out=%0d ov=%b required 12 0", out, overflow);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) do_op(PUSH, i + 1);
    n_checks++;
    if (full !== 1'b1) begin
      n_errors++;
      $display("FAIL full_flag full=%b required 1", full);
    end
    do_op(PUSH, 6);
    do_op(DUP, 0);
    do_op(POP, 0);
    n_checks++;
    if (out !== 4'd4) begin
      n_errors++;
      $display("FAIL top_after_reject out=%0d required 4", out);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    do_op(POP, 0);
    do_op(PUSH, 1);
    do_op(ADD, 0);
    do_op(SWAP, 0);
    do_op(MUL, 0);
    do_op(SUB, 0);
    n_checks++;
    if (empty !== 1'b0 || full !== 1'b0) begin
      n_errors++;
      $display("FAIL sp_one_after_rejects empty=%b full=%b required 0 0", empty, full);
    end
  endtask

  task automatic test_swap_and_mul_reset();
    apply_reset();
    do_op(PUSH, 1);
    do_op(PUSH, 2);
    do_op(SWAP, 0);
    do_op(POP, 0);
    n_checks++;
    if (out !== 4'd1) begin
      n_errors++;
      $display("FAIL swap_pop out=%0d required 1", out);
    end
    do_op(POP, 0);
    do_op(PUSH, 3);
    do_op(PUSH, 5);
    @(negedge clk);
    opcode   = MUL;
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    m_out = 0;
    m_ov  = 0;
    n_checks++;
    if (empty !== 1'b1 || out !== '0 || op_ready !== 1'b1 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_mul empty=%b out=%0d rdy=%b ov=%b required 1 0 1 0",
               empty, out, op_ready, overflow);
    end
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || op_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL aborted_mul cycle=%0d out_valid=%b rdy=%b required 0 1", i, out_valid, op_ready);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        opcode = 3'($urandom_range(0, 7));
        in     = N'($urandom_range(0, MASK));
        n_checks++;
        if (out_valid !== 1'b0 || error !== 1'b0 || op_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL idle_cycle i=%0d out_valid=%b err=%b rdy=%b required 0 0 1",
                   i, out_valid, error, op_ready);
        end
      end else begin
        do_op(3'($urandom_range(0, 7)), int'($urandom_range(0, MASK)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_pop();
    test_overflow();
    test_mul();
    test_full();
    test_underflow();
    test_swap_and_mul_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
